enemy_move_scheduler: RTL

- Owns the positions of up to N_ENEMY chasing mask enemies and advances them one pixel toward the player on a periodic move tick.
- Runs a round-robin sweep FSM that uses one shared step datapath, one enemy per clock.
- Handles spawn and kill requests, and exports packed position, direction and active vectors.
- Per-enemy render units read these outputs.

---
 rtl/enemy_move_scheduler.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/enemy_move_scheduler.sv
// enemy_move_scheduler
// Owns the positions of up to N_ENEMY chasing enemies and steps each one
// pixel toward the player on every move tick. A round-robin sweep FSM shares
// a single step datapath, handling one slot per clock.
//
// Optional feature macro: ENEMY_PAUSE_EN (adds input 'pause'; while high the
// tick counter freezes, no move tick is raised and no spawn is accepted).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   target_x/target_y   player position (10 b each)
//   speed_offset        shortens the tick period (limit = TIME_MAX - offset)
//   spawn_req           level request; spawn_ack/spawn_idx report a fill
//   spawn_full          all slots occupied (combinational from registers)
//   kill_valid/kill_idx clear one slot's active flag
//   enemy_x/enemy_y     packed positions, slot i at [10i+9:10i]
//   enemy_dir           0 = LEFT, 1 = RIGHT
//   enemy_active        slot occupied
//   busy                sweep in progress
//   move_tick           one-cycle pulse at end of each period
module enemy_move_scheduler #(
    parameter int unsigned N_ENEMY    = 4,
    parameter int unsigned TIME_MAX   = 4600000,
    parameter int unsigned ZONE_Y_MAX = 231,
    parameter int unsigned SPAWN_X    = 601,
    parameter int unsigned SPAWN_Y    = 33
) (
`ifdef ENEMY_PAUSE_EN
    input  logic                    pause,
`endif
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              target_x,
    input  logic [9:0]              target_y,
    input  logic [25:0]             speed_offset,
    input  logic                    spawn_req,
    output logic                    spawn_ack,
    output logic [2:0]              spawn_idx,
    output logic                    spawn_full,
    input  logic                    kill_valid,
    input  logic [2:0]              kill_idx,
    output logic [10*N_ENEMY-1:0]   enemy_x,
    output logic [10*N_ENEMY-1:0]   enemy_y,
    output logic [N_ENEMY-1:0]      enemy_dir,
    output logic [N_ENEMY-1:0]      enemy_active,
    output logic                    busy,
    output logic                    move_tick
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CNT_W   = 26;
    localparam int unsigned IDX_W   = 3;

    localparam logic [CNT_W-1:0]   TIME_MAX_C = CNT_W'(TIME_MAX);
    localparam logic [COORD_W-1:0] ZONE_Y_C   = COORD_W'(ZONE_Y_MAX);
    localparam logic [COORD_W-1:0] SPAWN_X_C  = COORD_W'(SPAWN_X);
    localparam logic [COORD_W-1:0] SPAWN_Y_C  = COORD_W'(SPAWN_Y);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_ENEMY - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e                             state_q;
    logic [IDX_W-1:0]                   idx_q;
    logic                               busy_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic                               tick_q;
    logic                               ack_q;
    logic [IDX_W-1:0]                   ack_idx_q;
    logic [N_ENEMY-1:0][COORD_W-1:0]    x_q;
    logic [N_ENEMY-1:0][COORD_W-1:0]    y_q;
    logic [N_ENEMY-1:0]                 dir_q;
    logic [N_ENEMY-1:0]                 active_q;

    logic                               pause_c;
    logic [CNT_W-1:0]                   limit_c;
    logic [CNT_W-1:0]                   cnt_d;
    logic                               tick_d;
    logic [N_ENEMY-1:0]                 kill_hit_c;
    logic                               free_any_c;
    logic [IDX_W-1:0]                   free_idx_c;
    logic                               spawn_ok_c;
    logic [COORD_W-1:0]                 cur_x_c;
    logic [COORD_W-1:0]                 cur_y_c;
    logic                               cur_dir_c;
    logic                               cur_act_c;
    logic                               step_en_c;
    logic [COORD_W-1:0]                 step_x_d;
    logic [COORD_W-1:0]                 step_y_d;
    logic                               step_dir_d;

    // Pause source (tied low when the feature is compiled out)
    always_comb begin
`ifdef ENEMY_PAUSE_EN
        pause_c = pause;
`else
        pause_c = 1'b0;
`endif
    end

    // Tick period: limit clamps to 1 once the offset reaches TIME_MAX
    always_comb begin
        limit_c = (speed_offset >= TIME_MAX_C) ? CNT_W'(1) : (TIME_MAX_C - speed_offset);
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (!pause_c) begin
            if (cnt_q == limit_c) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else if (cnt_q > limit_c) begin
                // limit shrank below the running count: silent wrap
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Lowest free slot; a slot being killed this cycle is not free yet
    always_comb begin
        kill_hit_c = '0;
        free_any_c = 1'b0;
        free_idx_c = '0;
        for (int i = 0; i < int'(N_ENEMY); i++) begin
            kill_hit_c[i] = kill_valid && (kill_idx == IDX_W'(i));
        end
        for (int i = int'(N_ENEMY) - 1; i >= 0; i--) begin
            if (!active_q[i] && !kill_hit_c[i]) begin
                free_any_c = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
        spawn_ok_c = (state_q == IDLE) && spawn_req && !pause_c && free_any_c;
    end

    // Shared step datapath for the slot under the sweep pointer
    always_comb begin
        cur_x_c   = '0;
        cur_y_c   = '0;
        cur_dir_c = 1'b0;
        cur_act_c = 1'b0;
        for (int i = 0; i < int'(N_ENEMY); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x_c   = x_q[i];
                cur_y_c   = y_q[i];
                cur_dir_c = dir_q[i];
                cur_act_c = active_q[i];
            end
        end
        step_en_c = (state_q == SWEEP) && cur_act_c && (target_y <= ZONE_Y_C);

        step_x_d = cur_x_c;
        if (cur_x_c > target_x) begin
            step_x_d = cur_x_c - COORD_W'(1);
        end else if (cur_x_c < target_x) begin
            step_x_d = cur_x_c + COORD_W'(1);
        end

        step_y_d = cur_y_c;
        if (cur_y_c > target_y) begin
            step_y_d = cur_y_c - COORD_W'(1);
        end else if (cur_y_c < target_y) begin
            step_y_d = cur_y_c + COORD_W'(1);
        end

        // Facing follows the pre-step x comparison
        step_dir_d = cur_dir_c;
        if (target_x < cur_x_c) begin
            step_dir_d = 1'b0;
        end else if (target_x > cur_x_c) begin
            step_dir_d = 1'b1;
        end
    end

    // Tick counter, sweep FSM, spawn/kill and slot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
            ack_idx_q <= '0;
            dir_q     <= '1;
            active_q  <= '0;
            for (int i = 0; i < int'(N_ENEMY); i++) begin
                x_q[i] <= SPAWN_X_C;
                y_q[i] <= SPAWN_Y_C;
            end
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            ack_q  <= spawn_ok_c;
            if (spawn_ok_c) begin
                ack_idx_q <= free_idx_c;
            end

            case (state_q)
                IDLE: begin
                    if (tick_q) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Ticks arriving here are dropped
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase

            for (int i = 0; i < int'(N_ENEMY); i++) begin
                if (spawn_ok_c && (free_idx_c == IDX_W'(i))) begin
                    x_q[i]      <= SPAWN_X_C;
                    y_q[i]      <= SPAWN_Y_C;
                    dir_q[i]    <= 1'b1;
                    active_q[i] <= 1'b1;
                end
                if (step_en_c && (idx_q == IDX_W'(i))) begin
                    x_q[i]   <= step_x_d;
                    y_q[i]   <= step_y_d;
                    dir_q[i] <= step_dir_d;
                end
                // Kill wins over a concurrent step; position is left as written
                if (kill_hit_c[i]) begin
                    active_q[i] <= 1'b0;
                end
            end
        end
    end

    assign spawn_ack    = ack_q;
    assign spawn_idx    = ack_idx_q;
    assign spawn_full   = &active_q;
    assign enemy_x      = x_q;
    assign enemy_y      = y_q;
    assign enemy_dir    = dir_q;
    assign enemy_active = active_q;
    assign busy         = busy_q;
    assign move_tick    = tick_q;

endmodule
